cuckoo_insert_ctrl: RTL and testbench

Sequencing controller for the two-table cuckoo hash insert path. It accepts one 32-bit key at a time and issues placement requests alternately to the table-1 and table-2 insert stages. Each evicted key is re-driven into the opposite table until a request completes without eviction, the kick limit is reached, or a stage fails to answer. The block sits between the key source and the table stages, and owns insert completion status and statistics.

---
 rtl/cuckoo_insert_if.sv | 41 ++++
 rtl/cuckoo_insert_ctrl.sv | 144 ++++++++++++++
 tb/tb_cuckoo_insert_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cuckoo_insert_if.sv
// Handshake bundle between the cuckoo insert controller, its key source and the table stages.
// The master modport is the controller; the slave modport is the surrounding environment.
interface cuckoo_insert_if #(
  parameter int WIDTH = 32,
  parameter int KW    = 5
);
  logic             in_valid;
  logic [WIDTH-1:0] in_key;
  logic             in_ready;

  logic             st_req;
  logic             st_sel;
  logic [WIDTH-1:0] st_key;
  logic             st_ack;
  logic             st_evict;
  logic [WIDTH-1:0] st_evict_key;

  logic             done_valid;
  logic             done_ok;
  logic             done_timeout;
  logic [KW-1:0]    done_kicks;
  logic [WIDTH-1:0] done_key;

  logic             busy;
  logic [15:0]      ins_count;
  logic [15:0]      fail_count;

  modport master (
    input  in_valid, in_key, st_ack, st_evict, st_evict_key,
    output in_ready, st_req, st_sel, st_key,
           done_valid, done_ok, done_timeout, done_kicks, done_key,
           busy, ins_count, fail_count
  );

  modport slave (
    output in_valid, in_key, st_ack, st_evict, st_evict_key,
    input  in_ready, st_req, st_sel, st_key,
           done_valid, done_ok, done_timeout, done_kicks, done_key,
           busy, ins_count, fail_count
  );
endinterface

// File: rtl/cuckoo_insert_ctrl.sv
// Cuckoo hash insert sequencer: alternates placement requests between the two table stages,
// re-driving each evicted key until it settles, the kick limit is hit, or a stage stops answering.
module cuckoo_insert_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MAX_KICKS   = 16,
  parameter int KW          = 5,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  cuckoo_insert_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  localparam logic [KW:0]   MAXK_EXT = (KW+1)'(MAX_KICKS);
  localparam logic [KW-1:0] MAXK     = KW'(MAX_KICKS);
  localparam logic [7:0]    TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] cur_key, cur_key_n;
  logic             sel, sel_n;
  logic [KW-1:0]    kicks, kicks_n;
  logic [7:0]       tmo, tmo_n;
  logic             d_ok, d_ok_n;
  logic             d_to, d_to_n;
  logic [KW-1:0]    d_kicks, d_kicks_n;
  logic [WIDTH-1:0] d_key, d_key_n;
  logic [15:0]      ins_cnt, ins_cnt_n;
  logic [15:0]      fail_cnt, fail_cnt_n;
  logic             kick_last;

  assign kick_last = (({1'b0, kicks} + (KW+1)'(1)) == MAXK_EXT);

  always_comb begin
    state_n    = state;
    cur_key_n  = cur_key;
    sel_n      = sel;
    kicks_n    = kicks;
    tmo_n      = tmo;
    d_ok_n     = d_ok;
    d_to_n     = d_to;
    d_kicks_n  = d_kicks;
    d_key_n    = d_key;
    ins_cnt_n  = ins_cnt;
    fail_cnt_n = fail_cnt;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          cur_key_n = bus.in_key;
          sel_n     = 1'b0;
          kicks_n   = '0;
          tmo_n     = '0;
          state_n   = REQ;
        end
      end
      REQ: begin
        tmo_n = tmo + 8'd1;
        // An ack in the same cycle as the last timeout tick still wins.
        if (bus.st_ack) begin
          if (!bus.st_evict) begin
            state_n   = DONE;
            d_ok_n    = 1'b1;
            d_to_n    = 1'b0;
            d_kicks_n = kicks;
            d_key_n   = '0;
          end else if (kick_last) begin
            state_n   = DONE;
            d_ok_n    = 1'b0;
            d_to_n    = 1'b0;
            d_kicks_n = MAXK;
            d_key_n   = bus.st_evict_key;
          end else begin
            kicks_n   = kicks + KW'(1);
            cur_key_n = bus.st_evict_key;
            sel_n     = ~sel;
            state_n   = GAP;
          end
        end else if (tmo == TMO_LAST) begin
          state_n   = DONE;
          d_ok_n    = 1'b0;
          d_to_n    = 1'b1;
          d_kicks_n = kicks;
          d_key_n   = cur_key;
        end
      end
      GAP: begin
        tmo_n   = '0;
        state_n = REQ;
      end
      DONE: begin
        if (d_ok) begin
          if (ins_cnt != '1) ins_cnt_n = ins_cnt + 16'd1;
        end else begin
          if (fail_cnt != '1) fail_cnt_n = fail_cnt + 16'd1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_key  <= '0;
      sel      <= 1'b0;
      kicks    <= '0;
      tmo      <= '0;
      d_ok     <= 1'b0;
      d_to     <= 1'b0;
      d_kicks  <= '0;
      d_key    <= '0;
      ins_cnt  <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_n;
      cur_key  <= cur_key_n;
      sel      <= sel_n;
      kicks    <= kicks_n;
      tmo      <= tmo_n;
      d_ok     <= d_ok_n;
      d_to     <= d_to_n;
      d_kicks  <= d_kicks_n;
      d_key    <= d_key_n;
      ins_cnt  <= ins_cnt_n;
      fail_cnt <= fail_cnt_n;
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.st_req       = (state == REQ);
  assign bus.st_sel       = sel;
  assign bus.st_key       = cur_key;
  assign bus.done_valid   = (state == DONE);
  assign bus.done_ok      = d_ok;
  assign bus.done_timeout = d_to;
  assign bus.done_kicks   = d_kicks;
  assign bus.done_key     = d_key;
  assign bus.ins_count    = ins_cnt;
  assign bus.fail_count   = fail_cnt;

endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Bench for cuckoo_insert_ctrl: directed scenarios plus random response plans, each insert's
// outcome predicted by a transaction-level walk over the planned stage responses.
module tb_cuckoo_insert_ctrl;
  localparam int W  = 32;
  localparam int MK = 4;
  localparam int KW = 5;
  localparam int AT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cuckoo_insert_if #(.WIDTH(W), .KW(KW)) bus ();

  cuckoo_insert_ctrl #(
    .WIDTH(W), .MAX_KICKS(MK), .KW(KW), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_ins  = 0;
  int exp_fail = 0;

  // Response plan per request: ack delay (>= AT means never ack), evict flag, evicted key.
  int          pd[8];
  bit          pe[8];
  logic [31:0] pk[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in an IDLE cycle; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_insert(input logic [31:0] key, input bit hold, input logic [31:0] nkey);
    logic [31:0] cur, e_key;
    logic [31:0] e_skey[8];
    int          kicks, cyc, nreq_e, r, w, c, nreq, idx;
    bit          e_ok, e_tmo, acked, gap_due, seen;

    cur = key; kicks = 0; cyc = 0; nreq_e = 0;
    e_ok = 0; e_tmo = 0; e_key = '0;
    for (int i = 0; i < 8; i++) e_skey[i] = '0;
    for (int i = 0; i < MK; i++) begin
      e_skey[i] = cur;
      nreq_e++;
      if (pd[i] >= AT) begin cyc += AT; e_tmo = 1; e_key = cur; break; end
      cyc += pd[i] + 1;
      if (!pe[i]) begin e_ok = 1; break; end
      kicks++;
      if (kicks == MK) begin e_key = pk[i]; break; end
      cur = pk[i];
      cyc += 1;
    end

    chk("in_ready_before_accept", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_key   = key;
    r = 0; w = 0; c = 0; nreq = 0; acked = 0; gap_due = 0; seen = 0;
    while (c < 300) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        bus.in_valid = hold;
        bus.in_key   = hold ? nkey : '0;
      end
      if (acked) begin r++; w = 0; acked = 0; end
      chk("busy_high", 32'(bus.busy), 1);
      chk("in_ready_low", 32'(bus.in_ready), 0);
      if (bus.done_valid) begin
        seen = 1;
        chk("gap_missing_at_done", 32'(gap_due), 0);
        chk("done_ok", 32'(bus.done_ok), 32'(e_ok));
        chk("done_timeout", 32'(bus.done_timeout), 32'(e_tmo));
        chk("done_kicks", 32'(bus.done_kicks), kicks);
        chk("done_key", bus.done_key, e_key);
        chk("done_cycle", c, cyc + 1);
        chk("request_count", nreq, nreq_e);
        bus.st_ack       = 1'($urandom_range(0, 1));
        bus.st_evict     = 1'($urandom_range(0, 1));
        bus.st_evict_key = $urandom;
        break;
      end else if (bus.st_req) begin
        idx = r & 7;
        if (w == 0) begin
          nreq++;
          chk("gap_before_rereq", 32'(gap_due), 0);
          chk("st_sel", 32'(bus.st_sel), r % 2);
          chk("st_key", bus.st_key, e_skey[idx]);
        end
        if (pd[idx] < AT && w == pd[idx]) begin
          bus.st_ack       = 1'b1;
          bus.st_evict     = pe[idx];
          bus.st_evict_key = pk[idx];
          acked   = 1;
          gap_due = pe[idx] && (r + 1 < MK);
        end else begin
          bus.st_ack       = 1'b0;
          bus.st_evict     = 1'($urandom_range(0, 1));
          bus.st_evict_key = $urandom;
        end
        w++;
      end else begin
        chk("gap_expected", 32'(gap_due), 1);
        gap_due = 0;
        bus.st_ack       = 1'($urandom_range(0, 1));
        bus.st_evict     = 1'($urandom_range(0, 1));
        bus.st_evict_key = $urandom;
      end
    end
    if (!seen) chk("done_within_budget", 0, 1);
    if (e_ok) exp_ins++; else exp_fail++;

    @(negedge clk);
    bus.st_ack   = 1'b0;
    bus.st_evict = 1'b0;
    chk("ins_count", 32'(bus.ins_count), exp_ins);
    chk("fail_count", 32'(bus.fail_count), exp_fail);
    chk("in_ready_after_done", 32'(bus.in_ready), 1);
    chk("busy_after_done", 32'(bus.busy), 0);
    chk("done_valid_pulse", 32'(bus.done_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] k, nk;
    bit          h;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_key = '0;
    bus.st_ack = 1'b0; bus.st_evict = 1'b0; bus.st_evict_key = '0;
    repeat (2) @(negedge clk);
    chk("rst_st_req", 32'(bus.st_req), 0);
    chk("rst_st_sel", 32'(bus.st_sel), 0);
    chk("rst_st_key", bus.st_key, 0);
    chk("rst_done_valid", 32'(bus.done_valid), 0);
    chk("rst_done_ok", 32'(bus.done_ok), 0);
    chk("rst_done_timeout", 32'(bus.done_timeout), 0);
    chk("rst_done_kicks", 32'(bus.done_kicks), 0);
    chk("rst_done_key", bus.done_key, 0);
    chk("rst_ins_count", 32'(bus.ins_count), 0);
    chk("rst_fail_count", 32'(bus.fail_count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Single insert placed at once.
    pd[0] = 0; pe[0] = 0; pk[0] = '0;
    do_insert(32'h0000_00AA, 0, '0);

    // Two-kick chain: 0x11 -> evicts 0x22 -> evicts 0x33 -> placed.
    pd[0] = 0; pe[0] = 1; pk[0] = 32'h22;
    pd[1] = 0; pe[1] = 1; pk[1] = 32'h33;
    pd[2] = 0; pe[2] = 0; pk[2] = '0;
    do_insert(32'h11, 0, '0);

    // Kick limit: every stage evicts, returning key+1.
    for (int i = 0; i < 8; i++) begin pd[i] = 0; pe[i] = 1; pk[i] = 32'h101 + 32'(i); end
    do_insert(32'h100, 0, '0);

    // Timeout on the first request, then a stray ack while idle.
    pd[0] = AT; pe[0] = 0; pk[0] = '0;
    do_insert(32'h5A5A, 0, '0);
    bus.st_ack = 1'b1; bus.st_evict = 1'b1; bus.st_evict_key = 32'hDEAD;
    @(negedge clk);
    bus.st_ack = 1'b0; bus.st_evict = 1'b0;
    chk("stray_ack_busy", 32'(bus.busy), 0);
    chk("stray_ack_st_req", 32'(bus.st_req), 0);
    chk("stray_ack_done_valid", 32'(bus.done_valid), 0);
    chk("stray_ack_fail_count", 32'(bus.fail_count), exp_fail);

    // Backpressure: second key held on in_valid during a 3-cycle-wait insert.
    pd[0] = 3; pe[0] = 0; pk[0] = '0;
    do_insert(32'h77, 1, 32'h88);
    pd[0] = 1; pe[0] = 0; pk[0] = '0;
    do_insert(32'h88, 0, '0);

    // Reset during the second request of a chain.
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_key = 32'h11;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_rst_req1", 32'(bus.st_req), 1);
    bus.st_ack = 1'b1; bus.st_evict = 1'b1; bus.st_evict_key = 32'h22;
    @(negedge clk);
    bus.st_ack = 1'b0; bus.st_evict = 1'b0;
    chk("mid_rst_gap", 32'(bus.st_req), 0);
    @(negedge clk);
    chk("mid_rst_req2", 32'(bus.st_req), 1);
    chk("mid_rst_req2_key", bus.st_key, 32'h22);
    chk("mid_rst_req2_sel", 32'(bus.st_sel), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("after_rst_st_req", 32'(bus.st_req), 0);
    chk("after_rst_in_ready", 32'(bus.in_ready), 1);
    chk("after_rst_done_valid", 32'(bus.done_valid), 0);
    chk("after_rst_ins_count", 32'(bus.ins_count), 0);
    chk("after_rst_fail_count", 32'(bus.fail_count), 0);
    exp_ins = 0; exp_fail = 0;

    // Random response plans, some with a held follow-on key.
    k = $urandom;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) begin
        pd[i] = ($urandom_range(0, 19) == 0) ? AT : int'($urandom_range(0, 3));
        pe[i] = ($urandom_range(0, 2) != 0);
        pk[i] = $urandom;
      end
      h  = 1'($urandom_range(0, 1));
      nk = $urandom;
      do_insert(k, h, nk);
      k = nk;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
